// File: rtl/rv_multiport_reg_file_if.sv
// Bundle of the decode/writeback-facing signals of rv_multiport_reg_file.
// The master side (pipeline) drives reads, writes, reservations and clear requests.
interface rv_multiport_reg_file_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  // No valid/ready pairing per transfer: ready=1 means every request presented
  // in that cycle is accepted at the next posedge; while ready=0 they are dropped.
  logic                                   clr_req;
  logic                                   ready;
  logic [NUM_READ_PORTS*AW-1:0]           rs_addr;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   rs_data;
  logic [NUM_WRITE_PORTS-1:0]             wen;
  logic [NUM_WRITE_PORTS*AW-1:0]          waddr;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]  wdata;
  logic                                   rsv_en;
  logic [AW-1:0]                          rsv_addr;
  logic [NUM_REGS-1:0]                    busy_mask;

  modport master (
    output clr_req, rs_addr, wen, waddr, wdata, rsv_en, rsv_addr,
    input  ready, rs_data, busy_mask
  );

  modport slave (
    input  clr_req, rs_addr, wen, waddr, wdata, rsv_en, rsv_addr,
    output ready, rs_data, busy_mask
  );
endinterface

// File: rtl/rv_multiport_reg_file.sv
// Multi-port register file with busy-bit scoreboard and sequential clear FSM.
// Define RV_REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module rv_multiport_reg_file #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ZERO_REG        = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  rv_multiport_reg_file_if.slave bus,
  output logic                   state_dbg
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [AW-1:0]         waddr_a [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_WRITE_PORTS];
  logic [NUM_WRITE_PORTS-1:0] wr_ok;
  logic                  rsv_ok;
  logic [AW-1:0]         rd_addr_a [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] rd_val_a  [NUM_READ_PORTS];

  // A write is accepted only in IDLE and never targets a hardwired zero register.
  always_comb begin
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      waddr_a[w] = bus.waddr[w*AW +: AW];
      wdata_a[w] = bus.wdata[w*DATA_WIDTH +: DATA_WIDTH];
      wr_ok[w]   = (state_q == IDLE) && bus.wen[w] &&
                   !((ZERO_REG != 0) && (waddr_a[w] == '0));
    end
    rsv_ok = (state_q == IDLE) && bus.rsv_en &&
             !((ZERO_REG != 0) && (bus.rsv_addr == '0));
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    regs_d    = regs_q;
    case (state_q)
      CLEAR: begin
        regs_d[clr_cnt_q] = '0;
        clr_cnt_d         = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_REG) state_d = IDLE;
      end
      IDLE: begin
        // Ascending loop: the highest-index port's write lands last and wins.
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
          if (wr_ok[w]) begin
            regs_d[waddr_a[w]] = wdata_a[w];
            busy_d[waddr_a[w]] = 1'b0;
          end
        end
        // Set after the clears so a new producer overrides a retiring one.
        if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Storage is zeroed by the clear FSM, so it carries no reset.
  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  always_comb begin
    bus.rs_data = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_addr_a[p] = bus.rs_addr[p*AW +: AW];
      rd_val_a[p]  = regs_q[rd_addr_a[p]];
`ifdef RV_REG_FILE_BYPASS_EN
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (wr_ok[w] && (waddr_a[w] == rd_addr_a[p])) rd_val_a[p] = wdata_a[w];
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr_a[p] == '0)) rd_val_a[p] = '0;
      if (state_q != IDLE) rd_val_a[p] = '0;
      bus.rs_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_val_a[p];
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy_mask = busy_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_rv_multiport_reg_file.sv
// Directed self-checking bench for rv_multiport_reg_file (default parameters).
// Inputs change and outputs are sampled just after each falling edge.
module tb_rv_multiport_reg_file;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic CLK;
  logic RST;
  logic state_dbg;
  int   checks;
  int   errors;

  rv_multiport_reg_file_if #(.DATA_WIDTH(DW), .NUM_REGS(NR),
    .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2)) bus ();

  rv_multiport_reg_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(2),
    .NUM_WRITE_PORTS(2), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .state_dbg(state_dbg));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.clr_req  = 1'b0;
    bus.wen      = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic set_write(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen[port]             = 1'b1;
    bus.waddr[port*AW +: AW]  = a;
    bus.wdata[port*DW +: DW]  = d;
  endtask

  task automatic set_read(input int port, input logic [AW-1:0] a);
    bus.rs_addr[port*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rd(input int port);
    return bus.rs_data[port*DW +: DW];
  endfunction

  task automatic next_sample();
    @(negedge CLK);
    idle_inputs();
  endtask

  // Samples 32 cycles of CLEAR: ready low, reads zero, busy_mask as expected.
  task automatic expect_clear(input string tag, input logic [31:0] exp_busy,
                              input int write_at);
    for (int i = 0; i < 32; i++) begin
      set_read(0, AW'($urandom_range(0, NR - 1)));
      set_read(1, AW'($urandom_range(0, NR - 1)));
      if (i == write_at) begin
        set_write(0, 5'd12, 32'h0000_0077);
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd13;
      end
      #1;
      check({tag, "_ready"}, {31'd0, bus.ready}, 32'd0);
      check({tag, "_rd0"}, rd(0), 32'd0);
      check({tag, "_rd1"}, rd(1), 32'd0);
      check({tag, "_busy"}, bus.busy_mask, exp_busy);
      next_sample();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    bus.rs_addr = '0;
    RST = 1'b1;

    // Reset and initial clear
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    expect_clear("init", 32'd0, -1);
    #1;
    check("init_ready_up", {31'd0, bus.ready}, 32'd1);
    check("init_busy", bus.busy_mask, 32'd0);

    // Basic write then read
    set_write(0, 5'd5, 32'hDEAD_BEEF);
    next_sample();
    set_read(0, 5'd5);
    set_write(1, 5'd0, 32'h0000_1234);
    #1;
    check("wr_rd_reg5", rd(0), 32'hDEAD_BEEF);
    next_sample();
    set_read(1, 5'd0);
    #1;
    check("reg0_zero", rd(1), 32'd0);

    // Same-address collision: port 1 wins
    set_write(0, 5'd7, 32'h0000_0011);
    set_write(1, 5'd7, 32'h0000_0022);
    next_sample();
    set_read(0, 5'd7);
    set_read(1, 5'd7);
    #1;
    check("collide_p0", rd(0), 32'h0000_0022);
    check("collide_p1", rd(1), 32'h0000_0022);

    // Same-cycle write/read of reg 3
    set_write(0, 5'd3, 32'hA5A5_A5A5);
    set_read(0, 5'd3);
    set_read(1, 5'd5);
    #1;
`ifdef RV_REG_FILE_BYPASS_EN
    check("bypass_same", rd(0), 32'hA5A5_A5A5);
`else
    check("bypass_same", rd(0), 32'd0);
`endif
    check("bypass_other", rd(1), 32'hDEAD_BEEF);
    next_sample();
    #1;
    check("bypass_next", rd(0), 32'hA5A5_A5A5);

    // Scoreboard
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    next_sample();
    #1;
    check("rsv9_set", bus.busy_mask, 32'h0000_0200);
    set_write(1, 5'd9, 32'h0000_0009);
    next_sample();
    #1;
    check("rsv9_clr", bus.busy_mask, 32'd0);
    set_write(0, 5'd9, 32'h0000_0099);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    next_sample();
    #1;
    check("rsv9_wr_same", bus.busy_mask, 32'h0000_0200);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    next_sample();
    #1;
    check("rsv0_ignored", bus.busy_mask, 32'h0000_0200);
    set_write(0, 5'd9, 32'h0000_0999);
    next_sample();
    #1;
    check("rsv9_final_clr", bus.busy_mask, 32'd0);

    // Clear request keeps busy bits, drops writes during clear
    set_write(0, 5'd5, 32'h0000_0055);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd6;
    next_sample();
    bus.clr_req = 1'b1;
    #1;
    check("pre_clr_ready", {31'd0, bus.ready}, 32'd1);
    check("pre_clr_busy", bus.busy_mask, 32'h0000_0040);
    next_sample();
    expect_clear("clrreq", 32'h0000_0040, 20);
    set_read(0, 5'd5);
    set_read(1, 5'd12);
    #1;
    check("clr_ready_up", {31'd0, bus.ready}, 32'd1);
    check("clr_reg5", rd(0), 32'd0);
    check("clr_reg12_dropped", rd(1), 32'd0);
    check("clr_busy_kept", bus.busy_mask, 32'h0000_0040);

    // Reset in the middle of a clear restarts it
    bus.clr_req = 1'b1;
    next_sample();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("midclr_ready", {31'd0, bus.ready}, 32'd0);
      next_sample();
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    expect_clear("rstclr", 32'd0, -1);
    set_read(0, 5'd7);
    #1;
    check("rstclr_ready_up", {31'd0, bus.ready}, 32'd1);
    check("rstclr_busy", bus.busy_mask, 32'd0);
    check("rstclr_reg7", rd(0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
